// File: rtl/fetch_ctrl_if.sv
// Bus between fetch_ctrl and its environment: decoded branch ops and PC in,
// jump request and status out.
interface fetch_ctrl_if #(
    parameter int D  = 10,
    parameter int CW = 16
);
    logic          start;
    logic [2:0]    br_op;
    logic [D-1:0]  br_target;
    logic          zero_flag;
    logic [D-1:0]  prog_ctr;
    logic          jb_en;
    logic [D-1:0]  target;
    logic          done;
    logic          err;
    logic [CW-1:0] cycle_cnt;

    modport master (
        output start, br_op, br_target, zero_flag, prog_ctr,
        input  jb_en, target, done, err, cycle_cnt
    );

    modport slave (
        input  start, br_op, br_target, zero_flag, prog_ctr,
        output jb_en, target, done, err, cycle_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Program sequencing controller: start/halt control, branch resolution,
// return-address stack and run-cycle counter driving the PC's jump inputs.
module fetch_ctrl #(
    parameter int D        = 10,
    parameter int RS_DEPTH = 4,
    parameter int CW       = 16
) (
    input logic         clk,
    input logic         reset,
    fetch_ctrl_if.slave bus
);
    localparam int AW  = $clog2(RS_DEPTH);
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(RS_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BZ   = 3'd2,
        OP_BNZ  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_HALT = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    state_e         r_state;
    state_e         w_next;
    logic [SPW-1:0] r_sp;
    logic [D-1:0]   r_stack [RS_DEPTH];
    logic           r_err;
    logic [CW-1:0]  r_cnt;

    logic           w_push;
    logic           w_pop;
    logic           w_set_err;
    logic           w_restart;
    logic [SPW-1:0] w_sp_dec;
    logic [D-1:0]   w_ret_addr;
    logic [D-1:0]   w_top;
    op_e            w_op;

    assign w_op       = op_e'(bus.br_op);
    assign w_sp_dec   = r_sp - SPW'(1);
    assign w_ret_addr = bus.prog_ctr + D'(1);
    // When sp is 0 the index wraps to the last entry; the value is unused then.
    assign w_top      = r_stack[w_sp_dec[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_err = 1'b0;
        w_restart = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next    = RUN;
                    w_restart = 1'b1;
                end
            end
            RUN: begin
                case (w_op)
                    OP_CALL: begin
                        if (r_sp == SP_FULL) begin
                            w_set_err = 1'b1;
                            w_next    = HALT;
                        end else begin
                            w_push = 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (r_sp == '0) begin
                            w_set_err = 1'b1;
                            w_next    = HALT;
                        end else begin
                            w_pop = 1'b1;
                        end
                    end
                    OP_HALT: w_next = HALT;
                    default: ;
                endcase
            end
            HALT: begin
                if (bus.start) begin
                    w_next    = RUN;
                    w_restart = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // PC has no stall input, so idle/halt pin it by forcing a jump.
    always_comb begin
        bus.jb_en  = 1'b1;
        bus.target = '0;
        unique case (r_state)
            IDLE: ;
            RUN: begin
                bus.target = bus.br_target;
                case (w_op)
                    OP_JMP:  bus.jb_en = 1'b1;
                    OP_BZ:   bus.jb_en = bus.zero_flag;
                    OP_BNZ:  bus.jb_en = ~bus.zero_flag;
                    OP_CALL: bus.jb_en = (r_sp != SP_FULL);
                    OP_RET: begin
                        bus.jb_en  = (r_sp != '0);
                        bus.target = w_top;
                    end
                    OP_HALT: bus.target = bus.prog_ctr;
                    default: bus.jb_en = 1'b0;
                endcase
            end
            HALT: begin
                if (!bus.start) begin
                    bus.target = bus.prog_ctr;
                end
            end
            default: ;
        endcase
    end

    assign bus.done      = (r_state == HALT);
    assign bus.err       = r_err;
    assign bus.cycle_cnt = r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sp  <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_restart) begin
            r_sp  <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (r_state == RUN && r_cnt != '1) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_push) begin
                r_stack[r_sp[AW-1:0]] <= w_ret_addr;
                r_sp                  <= r_sp + SPW'(1);
            end
            if (w_pop) begin
                r_sp <= w_sp_dec;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized ops
// against a queue-based behavioural model, with a PC model driven by the DUT.
module tb_fetch_ctrl;
    localparam int D     = 10;
    localparam int CW    = 6;
    localparam int DEPTH = 4;
    localparam int unsigned PCM  = 1 << D;
    localparam int unsigned CMAX = (1 << CW) - 1;

    localparam int unsigned NOP = 0, JMP = 1, BZ = 2, BNZ = 3, CALL = 4, RET = 5, HLT = 6;

    typedef enum {M_IDLE, M_RUN, M_HALT} mode_e;

    logic clk;
    logic reset;

    fetch_ctrl_if #(.D(D), .CW(CW)) bus ();

    fetch_ctrl #(.D(D), .RS_DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mode_e       m_mode;
    int unsigned m_stk[$];
    int unsigned m_err;
    int unsigned m_cnt;
    int unsigned m_pc;
    int unsigned obs_pc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_stk.delete();
        m_err  = 0;
        m_cnt  = 0;
    endtask

    // One clock cycle: drive, check combinational + registered outputs, advance model and PC.
    task automatic step(input bit st, input int unsigned op, input int unsigned tgt, input bit zf);
        bit          e_jb;
        int unsigned e_tg;
        bit          o_jb;
        int unsigned o_tg;
        @(negedge clk);
        bus.start     = st;
        bus.br_op     = op[2:0];
        bus.br_target = tgt[D-1:0];
        bus.zero_flag = zf;
        bus.prog_ctr  = obs_pc[D-1:0];
        e_jb = 1'b1;
        e_tg = 0;
        case (m_mode)
            M_IDLE: ;
            M_HALT: if (!st) e_tg = m_pc;
            M_RUN: begin
                e_tg = tgt;
                case (op)
                    JMP:  e_jb = 1'b1;
                    BZ:   e_jb = zf;
                    BNZ:  e_jb = !zf;
                    CALL: e_jb = (m_stk.size() < DEPTH);
                    RET: begin
                        e_jb = (m_stk.size() > 0);
                        if (e_jb) e_tg = m_stk[$];
                    end
                    HLT:  e_tg = m_pc;
                    default: e_jb = 1'b0;
                endcase
            end
            default: ;
        endcase
        #1;
        o_jb = bus.jb_en;
        o_tg = 32'(bus.target);
        check_eq("jb_en", 32'(bus.jb_en), 32'(e_jb));
        if (e_jb) check_eq("target", 32'(bus.target), e_tg);
        check_eq("done", 32'(bus.done), (m_mode == M_HALT) ? 1 : 0);
        check_eq("err", 32'(bus.err), m_err);
        check_eq("cycle_cnt", 32'(bus.cycle_cnt), m_cnt);
        @(posedge clk);
        case (m_mode)
            M_IDLE: if (st) begin
                m_mode = M_RUN;
                m_cnt  = 0;
            end
            M_HALT: if (st) begin
                m_mode = M_RUN;
                m_stk.delete();
                m_err  = 0;
                m_cnt  = 0;
            end
            M_RUN: begin
                m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
                case (op)
                    CALL: if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % PCM);
                          else begin m_err = 1; m_mode = M_HALT; end
                    RET:  if (m_stk.size() > 0) void'(m_stk.pop_back());
                          else begin m_err = 1; m_mode = M_HALT; end
                    HLT:  m_mode = M_HALT;
                    default: ;
                endcase
            end
            default: ;
        endcase
        m_pc   = e_jb ? e_tg : (m_pc + 1) % PCM;
        obs_pc = o_jb ? o_tg : (obs_pc + 1) % PCM;
    endtask

    task automatic nops(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, NOP, 0, 0);
    endtask

    initial begin
        int unsigned r;
        int unsigned op;
        bit          st;

        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.br_op     = '0;
        bus.br_target = '0;
        bus.zero_flag = 1'b0;
        bus.prog_ctr  = '0;
        model_reset();
        m_pc   = 0;
        obs_pc = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_jb_en", 32'(bus.jb_en), 1);
        check_eq("rst_target", 32'(bus.target), 0);
        check_eq("rst_done", 32'(bus.done), 0);
        check_eq("rst_err", 32'(bus.err), 0);
        check_eq("rst_cnt", 32'(bus.cycle_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        // Start and straight-line execution
        step(1, NOP, 0, 0);
        check_eq("pc_start", obs_pc, 0);
        nops(5);
        check_eq("pc_after_nops", obs_pc, 5);
        #1 check_eq("cnt_5", 32'(bus.cycle_cnt), 5);

        // Conditional branches
        step(0, BZ, 20, 0);   check_eq("bz_not_taken", obs_pc, 6);
        step(0, BZ, 20, 1);   check_eq("bz_taken", obs_pc, 20);
        step(0, BNZ, 30, 1);  check_eq("bnz_not_taken", obs_pc, 21);
        step(0, BNZ, 30, 0);  check_eq("bnz_taken", obs_pc, 30);
        step(0, JMP, 5, 0);   check_eq("jmp", obs_pc, 5);

        // Single call/return
        step(0, CALL, 40, 0); check_eq("call", obs_pc, 40);
        nops(2);
        step(0, RET, 0, 0);   check_eq("ret_single", obs_pc, 6);

        // Nested calls unwind in reverse order
        step(0, CALL, 100, 0);
        step(0, CALL, 200, 0);
        step(0, CALL, 300, 0);
        step(0, CALL, 400, 0);
        check_eq("nest_deep", obs_pc, 400);
        step(0, RET, 0, 0);   check_eq("ret_4", obs_pc, 301);
        step(0, RET, 0, 0);   check_eq("ret_3", obs_pc, 201);
        step(0, RET, 0, 0);   check_eq("ret_2", obs_pc, 101);
        step(0, RET, 0, 0);   check_eq("ret_1", obs_pc, 7);

        // Overflow on the fifth nested call
        step(0, CALL, 100, 0);
        step(0, CALL, 200, 0);
        step(0, CALL, 300, 0);
        step(0, CALL, 400, 0);
        step(0, CALL, 500, 0);
        check_eq("ovf_no_jump", obs_pc, 401);
        #1;
        check_eq("ovf_err", 32'(bus.err), 1);
        check_eq("ovf_done", 32'(bus.done), 1);
        nops(3);
        check_eq("ovf_frozen", obs_pc, 401);
        step(1, NOP, 0, 0);
        check_eq("restart_pc", obs_pc, 0);
        #1;
        check_eq("restart_err", 32'(bus.err), 0);
        check_eq("restart_done", 32'(bus.done), 0);
        check_eq("restart_cnt", 32'(bus.cycle_cnt), 0);

        // Underflow on return with empty stack
        step(0, RET, 0, 0);
        check_eq("udf_no_jump", obs_pc, 1);
        #1;
        check_eq("udf_err", 32'(bus.err), 1);
        check_eq("udf_done", 32'(bus.done), 1);
        step(1, NOP, 0, 0);

        // Explicit HALT holds the PC
        step(0, JMP, 9, 0);
        step(0, HLT, 0, 0);
        for (int unsigned i = 0; i < 10; i++) begin
            step(0, NOP, 0, 0);
            check_eq("halt_hold", obs_pc, 9);
        end
        step(1, NOP, 0, 0);
        check_eq("halt_restart_pc", obs_pc, 0);
        #1 check_eq("halt_restart_cnt", 32'(bus.cycle_cnt), 0);

        // start during RUN is ignored; counter saturates
        step(1, NOP, 0, 0);
        check_eq("start_in_run", obs_pc, 1);
        nops(70);
        #1 check_eq("cnt_sat", 32'(bus.cycle_cnt), CMAX);

        // Randomized ops
        for (int unsigned i = 0; i < 500; i++) begin
            r  = $urandom_range(0, 15);
            op = (r < 8) ? r : (r < 11) ? CALL : (r < 14) ? RET : NOP;
            st = (m_mode == M_HALT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            step(st, op, $urandom_range(0, PCM - 1), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-RUN
        step(1, NOP, 0, 0);
        step(0, NOP, 0, 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.br_op = 3'(NOP);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_jb_en", 32'(bus.jb_en), 1);
        check_eq("arst_target", 32'(bus.target), 0);
        check_eq("arst_cnt", 32'(bus.cycle_cnt), 0);
        check_eq("arst_done", 32'(bus.done), 0);
        model_reset();
        @(posedge clk);
        m_pc   = 0;
        obs_pc = 0;
        @(negedge clk);
        reset = 1'b1;
        nops(3);
        check_eq("idle_after_rst", obs_pc, 0);
        step(1, NOP, 0, 0);
        nops(3);
        check_eq("run_after_rst", obs_pc, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the program counter: owns start/halt of program execution and drives the PC's absolute-jump inputs (jb_en, target) each cycle.
- Resolves decoded branch ops (jump, conditional branch on zero flag, call/return) and keeps a small hardware return-address stack.
- Holds the PC in idle/halt states by forcing a jump to a fixed or current address, because the PC has no stall input.
- Sits between the instruction decoder/ALU flags and the PC; reports done, error and run-cycle count to the test harness.

Parameters:
- D, 10, program counter / jump target width.
- RS_DEPTH, 4, return-address stack entries (power of 2, >=2).
- CW, 16, run-cycle counter width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state on assertion, released synchronously by the environment.
- start  input  1  single-cycle pulse; begins or restarts execution at address 0.
- br_op  input  3  decoded control op: 0 NOP, 1 JMP, 2 BZ, 3 BNZ, 4 CALL, 5 RET, 6 HALT, 7 reserved (treated as NOP).
- br_target  input  D  absolute destination for JMP/BZ/BNZ/CALL.
- zero_flag  input  1  ALU zero flag, valid in the same cycle as br_op.
- prog_ctr  input  D  current PC value.
- jb_en  output  1  PC absolute-jump enable (combinational).
- target  output  D  PC jump destination (combinational).
- done  output  1  high while in HALT.
- err  output  1  sticky stack overflow/underflow error.
- cycle_cnt  output  CW  count of cycles spent in RUN.

Behaviour:
- States: IDLE, RUN, HALT. Reset -> IDLE, stack pointer sp=0, err=0, cycle_cnt=0.
- Combinational outputs in IDLE: jb_en=1, target=0 (PC pinned at 0). done=0.
- IDLE: start=1 -> RUN next cycle. cycle_cnt is cleared on this transition.
- RUN: br_op is decoded in the same cycle; jb_en/target are combinational so the PC loads at the next edge.
  - NOP/reserved: jb_en=0 (PC increments).
  - JMP: jb_en=1, target=br_target.
  - BZ: jb_en=zero_flag. BNZ: jb_en=~zero_flag. target=br_target in both cases.
  - CALL: if sp<RS_DEPTH, push prog_ctr+1 (mod 2^D) and jump to br_target. If the stack is full: no push, no jump, err<=1, next state HALT.
  - RET: if sp>0, pop and jump to the popped address. If the stack is empty: no jump, err<=1, next state HALT.
  - HALT: jb_en=1, target=prog_ctr (PC holds); next state HALT.
  - cycle_cnt increments every RUN cycle and saturates at all-ones.
- HALT state: jb_en=1, target=prog_ctr (PC frozen); done=1. start=1 -> RUN with sp=0, err=0, cycle_cnt=0, and this cycle's jb_en=1, target=0 (restart at 0).
- start asserted while in RUN is ignored.
- Stack behaviour: LIFO, sp ranges 0..RS_DEPTH. Push/pop take effect at the clock edge; there is no simultaneous push and pop. Contents are not cleared on restart, only sp.
- err stays sticky until reset or restart from HALT.
- Reset asserted mid-operation: immediate return to IDLE; outputs revert to IDLE values without waiting for a clock edge.
- Arithmetic: prog_ctr+1 wraps at 2^D.

Test Plan:
- Reset, then start pulse with all NOPs for 5 cycles -> jb_en=0 in RUN; PC runs 0,1,2,3,4; cycle_cnt=5.
- At PC=3, br_op=BZ, br_target=20, zero_flag=0 -> no jump (PC=4). Repeat with zero_flag=1 -> target=20, jb_en=1, next PC=20. Check BNZ with inverted results.
- CALL at PC=5 to 40, then RET at PC=42 -> next PC 40, then 6. Nested 4 CALLs then 4 RETs return to the correct addresses in reverse order.
- Fifth nested CALL with RS_DEPTH=4 -> err=1, done=1 next cycle, PC frozen. RET with sp=0 -> same error response.
- HALT at PC=9 -> PC stays 9 for 10 cycles, done=1. start -> PC=0, done=0, err=0, cycle_cnt restarts from 0.
- Assert reset low mid-RUN (async, between edges) -> jb_en=1, target=0 immediately; after release, state is IDLE and start is required to run again.
